// File: rtl/uart_tx_framer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_framer_if                                                        |
// | Byte-in / frame-out bundle between the SPI side, framer and uart_tx.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface uart_tx_framer_if #(
  parameter int package_size = 8
);
  logic [package_size-1:0] data_in;
  logic                    data_valid;
  logic [package_size+1:0] frame;
  logic                    data_update_uart;
  logic                    busy;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    overflow;

  modport master (
    output data_in, data_valid,
    input  frame, data_update_uart, busy, fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  data_in, data_valid,
    output frame, data_update_uart, busy, fifo_full, fifo_empty, overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_framer                                                           |
// | Buffers bytes in a small FIFO and paces start/stop frames to uart_tx.    |
// | Option macro: UART_TX_FRAMER_DROP_CNT_EN adds a saturating drop counter.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_tx_framer #(
  parameter int transfer_speed = 4800,
  parameter int package_size   = 8,
  parameter int frequency      = 27_000_000,
  parameter int fifo_depth     = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  uart_tx_framer_if.slave       bus
`ifdef UART_TX_FRAMER_DROP_CNT_EN
  ,
  output      logic [7:0]       drop_count
`endif
);

  localparam int c_strobe    = frequency / transfer_speed;
  localparam int c_frame_gap = (package_size + 2) * c_strobe + 2;
  localparam int c_gap_bits  = $clog2(c_frame_gap + 1);
  localparam int c_gap_w     = (c_gap_bits > 27) ? c_gap_bits : 27;
  localparam int c_aw        = $clog2(fifo_depth);
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(c_frame_gap - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_gap_w-1:0]      r_gap;
  logic [package_size-1:0] r_mem [fifo_depth];
  logic [c_aw:0]           r_wr_ptr;
  logic [c_aw:0]           r_rd_ptr;
  logic [package_size+1:0] r_frame;
  logic                    r_pulse;
  logic                    r_overflow;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_drop;
  logic w_pop;

  // The extra pointer MSB separates "wrapped once" (full) from "equal" (empty).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_push  = bus.data_valid && !w_full;
  assign w_drop  = bus.data_valid && w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (c_aw + 1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (c_aw + 1)'(1);
      end
    end
  end

  // Reset parks the FSM in a full gap so a frame already in flight in
  // uart_tx is never cut short by an early start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_GAP;
      r_gap   <= c_gap_load;
      r_frame <= '1;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_frame <= {1'b1, r_mem[r_rd_ptr[c_aw-1:0]], 1'b0};
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          r_pulse <= 1'b1;
          r_gap   <= c_gap_load;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_gap == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - c_gap_w'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.frame            = r_frame;
  assign bus.data_update_uart = r_pulse;
  assign bus.overflow         = r_overflow;
  assign bus.fifo_empty       = w_empty;
  assign bus.fifo_full        = w_full;
  assign bus.busy             = (r_state != S_IDLE) || !w_empty;

`ifdef UART_TX_FRAMER_DROP_CNT_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= 8'd0;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_framer                                                        |
// | Vector table, directed corner sequences and random traffic vs. a model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_tx_framer;

  localparam int c_ts    = 2_700_000;
  localparam int c_freq  = 27_000_000;
  localparam int c_ps    = 8;
  localparam int c_depth = 8;
  localparam int c_fg    = (c_ps + 2) * (c_freq / c_ts) + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_framer_if #(.package_size(c_ps)) bus ();

`ifdef UART_TX_FRAMER_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  uart_tx_framer #(
    .transfer_speed (c_ts),
    .package_size   (c_ps),
    .frequency      (c_freq),
    .fifo_depth     (c_depth)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef UART_TX_FRAMER_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  typedef struct {
    logic [7:0] din;
    logic [9:0] exp_frame;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: byte queue plus the earliest edge at which a pop may occur.
  logic [7:0] mq [$];
  int         m_ready;
  int         m_pulse_edge;
  logic [9:0] m_frame;
  int         m_drops;

  int         obs_cyc   [$];
  logic [9:0] obs_frame [$];
  int         ovf_cyc   [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    int         pre;
    logic       acc;
    logic       drop;
    logic       pop;
    logic [7:0] b;
    bus.data_valid = v;
    bus.data_in    = d;
    @(posedge clk);
    cyc++;
    pre  = mq.size();
    acc  = v && (pre < c_depth);
    drop = v && (pre == c_depth);
    pop  = (pre > 0) && (cyc >= m_ready);
    if (pop) begin
      b            = mq.pop_front();
      m_frame      = {1'b1, b, 1'b0};
      m_pulse_edge = cyc + 1;
      m_ready      = cyc + c_fg + 2;
    end
    if (acc) mq.push_back(d);
    if (drop && (m_drops < 255)) m_drops++;
    #1;
    if (bus.data_update_uart === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_frame.push_back(bus.frame);
    end
    if (bus.overflow === 1'b1) ovf_cyc.push_back(cyc);
    chk("pulse", bus.data_update_uart, cyc == m_pulse_edge);
    chk("frame", bus.frame, m_frame);
    chk("overflow", bus.overflow, drop);
    chk("fifo_empty", bus.fifo_empty, mq.size() == 0);
    chk("fifo_full", bus.fifo_full, mq.size() == c_depth);
    chk("busy", bus.busy, (mq.size() != 0) || (cyc < m_ready - 1));
`ifdef UART_TX_FRAMER_DROP_CNT_EN
    chk("drop_count", drop_count, m_drops);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    rst_n        = 1'b0;
    mq.delete();
    m_frame      = '1;
    m_pulse_edge = -1;
    m_drops      = 0;
    #1;
    chk("rst_frame", bus.frame, 10'h3FF);
    chk("rst_pulse", bus.data_update_uart, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_empty", bus.fifo_empty, 1);
    chk("rst_full", bus.fifo_full, 0);
    chk("rst_busy", bus.busy, 1);
`ifdef UART_TX_FRAMER_DROP_CNT_EN
    chk("rst_drop_count", drop_count, 0);
`endif
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst_n          = 1'b1;
    bus.data_valid = 1'b0;
    m_ready        = cyc + 1 + c_fg;
  endtask

  task automatic clear_obs();
    obs_cyc.delete();
    obs_frame.delete();
    ovf_cyc.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   lat;
    int   p_edge;
    int   w_edge;

    tbl[0] = '{din: 8'hA5, exp_frame: 10'b1_10100101_0};
    tbl[1] = '{din: 8'h00, exp_frame: 10'b1_00000000_0};
    tbl[2] = '{din: 8'hFF, exp_frame: 10'b1_11111111_0};
    tbl[3] = '{din: 8'h3C, exp_frame: 10'b1_00111100_0};
    tbl[4] = '{din: 8'h01, exp_frame: 10'b1_00000001_0};
    tbl[5] = '{din: 8'h80, exp_frame: 10'b1_10000000_0};

    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    #2;
    do_reset(3);
    idle(c_fg + 5);

    // Single bytes: latency, frame layout and busy release after the pulse.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, tbl[i].din);
      w_edge = cyc;
      lat    = 0;
      for (int k = 0; k < 10; k++) begin
        step(1'b0, 8'h00);
        if (bus.data_update_uart === 1'b1) begin
          lat = cyc - w_edge;
          break;
        end
      end
      chk("tbl_latency", lat, 2);
      chk("tbl_frame", bus.frame, tbl[i].exp_frame);
      p_edge = cyc;
      for (int k = 0; k < 300; k++) begin
        step(1'b0, 8'h00);
        if (bus.busy === 1'b0) break;
      end
      chk("tbl_busy_release", cyc - p_edge, c_fg);
    end

    // Burst of three back-to-back writes.
    clear_obs();
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    idle(400);
    chk("burst_count", obs_cyc.size(), 3);
    chk("burst_no_ovf", ovf_cyc.size(), 0);
    if (obs_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("burst_frame", obs_frame[i], {1'b1, 8'(i + 1), 1'b0});
      chk("burst_gap1", obs_cyc[1] - obs_cyc[0], c_fg + 2);
      chk("burst_gap2", obs_cyc[2] - obs_cyc[1], c_fg + 2);
    end

    // Ten writes into an idle framer: one pops, eight buffer, the tenth drops.
    clear_obs();
    w_edge = cyc + 1;
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i));
    chk("ovf_count", ovf_cyc.size(), 1);
    if (ovf_cyc.size() == 1) chk("ovf_edge", ovf_cyc[0], w_edge + 9);
`ifdef UART_TX_FRAMER_DROP_CNT_EN
    chk("ovf_drop_count", drop_count, 1);
`endif
    idle(1100);
    chk("ovf_frames", obs_cyc.size(), 9);
    if (obs_cyc.size() == 9) begin
      for (int i = 0; i < 9; i++) chk("ovf_order", obs_frame[i], {1'b1, 8'(8'h10 + i), 1'b0});
    end

    // Write landing on the same edge as the pop of the only entry.
    clear_obs();
    step(1'b1, 8'h5A);
    step(1'b1, 8'h6B);
    chk("wp_not_empty", bus.fifo_empty, 0);
    chk("wp_not_full", bus.fifo_full, 0);
    idle(400);
    chk("wp_count", obs_cyc.size(), 2);
    if (obs_cyc.size() == 2) begin
      chk("wp_first", obs_frame[0], 10'b1_01011010_0);
      chk("wp_second", obs_frame[1], 10'b1_01101011_0);
      chk("wp_gap", obs_cyc[1] - obs_cyc[0], c_fg + 2);
    end

    // Reset while a gap is running, then write on the first edge after release.
    step(1'b1, 8'h77);
    idle(20);
    clear_obs();
    do_reset(3);
    step(1'b1, 8'h3C);
    w_edge = cyc;
    idle(150);
    chk("rg_count", obs_cyc.size(), 1);
    if (obs_cyc.size() == 1) begin
      chk("rg_delay", obs_cyc[0] - w_edge, c_fg + 1);
      chk("rg_frame", obs_frame[0], 10'b1_00111100_0);
    end

`ifdef UART_TX_FRAMER_DROP_CNT_EN
    do_reset(2);
    for (int i = 0; i < 310; i++) step(1'b1, 8'($urandom));
    chk("sat_drop_count", drop_count, 255);
    idle(c_depth * (c_fg + 2) + 100);
`endif

    // Random traffic: sparse, then dense enough to overflow, then drain.
    for (int i = 0; i < 2000; i++) step($urandom_range(0, 149) == 0, 8'($urandom));
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 14) == 0, 8'($urandom));
    idle(1200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
